// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file widths, indices and types.
// Reused by decode and writeback.
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: combinational read mux with r0 forcing.
// Optional same-cycle write forwarding under REG_FILE_BYPASS_EN.
module reg_file_read_port #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  addr,
`ifdef REG_FILE_BYPASS_EN
    input  logic                               write,
    input  logic                               reset,
    input  logic [ADDR_W-1:0]                  wr,
    input  logic [DATA_W-1:0]                  wd,
`endif
    output logic [DATA_W-1:0]                  rd
);

    import reg_file_pkg::*;

    logic is_zero;

    assign is_zero = (addr == ADDR_W'(ZERO_REG));

    always_comb begin
        rd = regs[addr];
`ifdef REG_FILE_BYPASS_EN
        // forward only a write that will actually land this edge
        if (write && reset && (wr != ADDR_W'(ZERO_REG)) && (wr == addr))
            rd = wd;
`endif
        if (is_zero)
            rd = '0;
    end

endmodule

// File: rtl/reg_file.sv
// reg_file: 2^ADDR_W x DATA_W register file, 2 read / 1 write, r0 = 0.
// Define REG_FILE_BYPASS_EN to forward write data to matching reads.
module reg_file #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] pr1,
    input  logic [ADDR_W-1:0] pr2,
    input  logic [ADDR_W-1:0] wr,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    import reg_file_pkg::*;

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] mem;

    // reset wins over write; index 0 is never stored to
    always_ff @(posedge clk) begin
        if (!reset)
            mem <= '0;
        else if (write && (wr != ADDR_W'(ZERO_REG)))
            mem[wr] <= wd;
    end

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rp1 (
        .regs  (mem),
        .addr  (pr1),
`ifdef REG_FILE_BYPASS_EN
        .write (write),
        .reset (reset),
        .wr    (wr),
        .wd    (wd),
`endif
        .rd    (rd1)
    );

    reg_file_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rp2 (
        .regs  (mem),
        .addr  (pr2),
`ifdef REG_FILE_BYPASS_EN
        .write (write),
        .reset (reset),
        .wr    (wr),
        .wd    (wd),
`endif
        .rd    (rd2)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vector table, corner sequences and
// randomized traffic against an array model of the register file.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic        write;
    logic [4:0]  pr1;
    logic [4:0]  pr2;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int checks;
    int failures;

    logic [31:0] model [32];

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .write (write),
        .pr1   (pr1),
        .pr2   (pr2),
        .wr    (wr),
        .wd    (wd),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rs;
        logic        w;
        logic [4:0]  a_wr;
        logic [31:0] a_wd;
        logic [4:0]  p1;
        logic [4:0]  p2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Expected read value from current inputs and architectural state
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0)
            return 32'd0;
`ifdef REG_FILE_BYPASS_EN
        if (write && reset && wr != 5'd0 && wr == a)
            return wd;
`endif
        return model[a];
    endfunction

    task automatic drive(input logic rs, input logic w,
                         input logic [4:0] a_wr,
                         input logic [31:0] a_wd,
                         input logic [4:0] p1,
                         input logic [4:0] p2);
        @(negedge clk);
        reset = rs;
        write = w;
        wr    = a_wr;
        wd    = a_wd;
        pr1   = p1;
        pr2   = p2;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                model[i] = 32'd0;
        end else if (write && wr != 5'd0) begin
            model[wr] = wd;
        end
        #1;
    endtask

    vec_t vt [10];

    initial begin
        checks   = 0;
        failures = 0;
        reset = 1'b0;
        write = 1'b0;
        wr    = '0;
        wd    = '0;
        pr1   = '0;
        pr2   = '0;
        for (int i = 0; i < 32; i++)
            model[i] = 32'd0;

        vt[0] = '{1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2,
                  32'h0, 32'h0};
        vt[1] = '{1'b1, 1'b1, 5'd1, 32'hFFFF_FFFF, 5'd1, 5'd2,
                  32'hFFFF_FFFF, 32'h0};
        vt[2] = '{1'b1, 1'b1, 5'd2, 32'h0FFF_FFFF, 5'd1, 5'd2,
                  32'hFFFF_FFFF, 32'h0FFF_FFFF};
        vt[3] = '{1'b1, 1'b1, 5'd3, 32'h00FF_FFFF, 5'd3, 5'd4,
                  32'h00FF_FFFF, 32'h0};
        vt[4] = '{1'b1, 1'b1, 5'd4, 32'h000F_FFFF, 5'd3, 5'd4,
                  32'h00FF_FFFF, 32'h000F_FFFF};
        vt[5] = '{1'b1, 1'b0, 5'd4, 32'h0000_FFFF, 5'd3, 5'd4,
                  32'h00FF_FFFF, 32'h000F_FFFF};
        vt[6] = '{1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd4,
                  32'h0, 32'h000F_FFFF};
        vt[7] = '{1'b0, 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd1,
                  32'h0, 32'h0};
        vt[8] = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3,
                  32'h0, 32'h0};
        vt[9] = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd5,
                  32'h0, 32'h0};

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].rs, vt[i].w, vt[i].a_wr, vt[i].a_wd,
                  vt[i].p1, vt[i].p2);
            #1;
            if (i > 0) begin
                chk($sformatf("vec%0d_pre_rd1", i), rd1, exp_rd(pr1));
                chk($sformatf("vec%0d_pre_rd2", i), rd2, exp_rd(pr2));
            end
            tick();
            chk($sformatf("vec%0d_rd1", i), rd1, vt[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd2, vt[i].e2);
        end

        // every address reads zero after the reset-priority edge
        for (int a = 0; a < 32; a++) begin
            pr1 = 5'(a);
            pr2 = 5'(31 - a);
            #1;
            chk($sformatf("clr_rd1_a%0d", a), rd1, 32'h0);
            chk($sformatf("clr_rd2_a%0d", a), rd2, 32'h0);
        end

        // same-cycle read/write of one register
        drive(1'b1, 1'b1, 5'd6, 32'hCAFE_F00D, 5'd6, 5'd6);
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("rw_same_pre", rd1, 32'hCAFE_F00D);
`else
        chk("rw_same_pre", rd1, 32'h0);
`endif
        tick();
        chk("rw_same_post1", rd1, 32'hCAFE_F00D);
        chk("rw_same_post2", rd2, 32'hCAFE_F00D);

        // reset mid-stream drops the in-flight write
        drive(1'b0, 1'b1, 5'd7, 32'h5555_AAAA, 5'd6, 5'd7);
        #1;
        chk("midrst_pre", rd1, 32'hCAFE_F00D);
        tick();
        drive(1'b1, 1'b0, 5'd7, 32'h0, 5'd6, 5'd7);
        #1;
        chk("midrst_r6", rd1, 32'h0);
        chk("midrst_r7", rd2, 32'h0);

        // randomized traffic, reads biased toward the write index
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 2) != 0),
                  a,
                  $urandom,
                  ($urandom_range(0, 2) == 0) ? a
                      : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? a
                      : 5'($urandom_range(0, 31)));
            #1;
            chk("rnd_pre_rd1", rd1, exp_rd(pr1));
            chk("rnd_pre_rd2", rd2, exp_rd(pr2));
            tick();
            chk("rnd_post_rd1", rd1, exp_rd(pr1));
            chk("rnd_post_rd2", rd2, exp_rd(pr2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
